// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Decode-stage operand reader. Drives the register file read
//               ports from the decoded source indices, selects each operand
//               (r0 / writeback bypass / register file), and hands the result
//               to EX through a one-entry registered valid/ready stage.
//               A 32-entry pending scoreboard marks registers that have a
//               write in flight. It is set when a writer issues and cleared
//               by writeback. Any source or destination that is pending
//               stalls the input.
// Build option: OPFETCH_WB_BYPASS_EN
//               defined   - a writeback landing in the same cycle supplies
//                           wb_wdata and releases the hazard on that register
//               undefined - operands come only from the register file, and
//                           a dependent instruction waits one cycle after wb
// Ports       :
//   clk, rstn                 clock, synchronous active-low reset
//   in_valid/in_ready         decoded instruction handshake
//   in_rs, in_rt              source register indices
//   in_rd, in_rd_wen          destination index and write enable
//   rf_raddr1/2, rf_rdata1/2  register file read ports (combinational read)
//   wb_wen/waddr/wdata        writeback commit seen by the register file
//   out_valid/out_ready       EX handshake
//   out_op1/2, out_rd/_wen    registered operands and forwarded destination
//   pending                   scoreboard bitmap, bit 0 always 0
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs,
    input  logic [ADDR_WIDTH-1:0] in_rt,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,

    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,

    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,

    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  out_rd_wen,

    output logic [31:0]           pending
);

    localparam logic [ADDR_WIDTH-1:0] c_R0 = '0;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic                  out_valid_q,  out_valid_d;
    logic [DATA_WIDTH-1:0] out_op1_q,    out_op1_d;
    logic [DATA_WIDTH-1:0] out_op2_q,    out_op2_d;
    logic [ADDR_WIDTH-1:0] out_rd_q,     out_rd_d;
    logic                  out_rd_wen_q, out_rd_wen_d;
    logic [31:0]           pending_q,    pending_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                  w_wb_commit;    // writeback to a real register
    logic                  w_hit_rs;       // writeback matches rs this cycle
    logic                  w_hit_rt;       // writeback matches rt this cycle
    logic                  w_hit_rd;       // writeback matches rd this cycle
    logic                  w_haz_rs;
    logic                  w_haz_rt;
    logic                  w_haz_rd;
    logic                  w_hazard;
    logic                  w_stage_free;   // output slot empty or draining now
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_op1;
    logic [DATA_WIDTH-1:0] w_op2;

    assign rf_raddr1   = in_rs;
    assign rf_raddr2   = in_rt;

    assign w_wb_commit = wb_wen && (wb_waddr != c_R0);

`ifdef OPFETCH_WB_BYPASS_EN
    // A writeback to the register being read lands this very edge, so its
    // data is already final: forward it and treat the register as not pending.
    assign w_hit_rs = wb_wen && (wb_waddr == in_rs);
    assign w_hit_rt = wb_wen && (wb_waddr == in_rt);
    assign w_hit_rd = wb_wen && (wb_waddr == in_rd);

    always_comb begin
        w_op1 = rf_rdata1;
        if (in_rs == c_R0) begin
            w_op1 = '0;
        end else if (w_hit_rs) begin
            w_op1 = wb_wdata;
        end
    end

    always_comb begin
        w_op2 = rf_rdata2;
        if (in_rt == c_R0) begin
            w_op2 = '0;
        end else if (w_hit_rt) begin
            w_op2 = wb_wdata;
        end
    end
`else
    // Without forwarding the register file holds the new value only after
    // the writeback edge, so the raw pending bit decides on its own.
    assign w_hit_rs = 1'b0;
    assign w_hit_rt = 1'b0;
    assign w_hit_rd = 1'b0;

    logic w_unused_wdata;
    assign w_unused_wdata = ^wb_wdata;

    assign w_op1 = (in_rs == c_R0) ? '0 : rf_rdata1;
    assign w_op2 = (in_rt == c_R0) ? '0 : rf_rdata2;
`endif

    // r0 never goes pending, so the index check only keeps the term explicit.
    assign w_haz_rs = (in_rs != c_R0) && pending_q[in_rs] && !w_hit_rs;
    assign w_haz_rt = (in_rt != c_R0) && pending_q[in_rt] && !w_hit_rt;
    // A second writer to a pending register waits as well (WAW), so the
    // single bit per register is always unambiguous.
    assign w_haz_rd = in_rd_wen && (in_rd != c_R0) && pending_q[in_rd] && !w_hit_rd;
    assign w_hazard = w_haz_rs || w_haz_rt || w_haz_rd;

    // in_ready deliberately ignores in_valid so that upstream can use it
    // without creating a combinational loop through its own valid.
    assign w_stage_free = !out_valid_q || out_ready;
    assign in_ready     = w_stage_free && !w_hazard;
    assign w_accept     = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Output stage next state
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d  = out_valid_q;
        out_op1_d    = out_op1_q;
        out_op2_d    = out_op2_q;
        out_rd_d     = out_rd_q;
        out_rd_wen_d = out_rd_wen_q;
        if (w_accept) begin
            out_valid_d  = 1'b1;
            out_op1_d    = w_op1;
            out_op2_d    = w_op2;
            out_rd_d     = in_rd;
            out_rd_wen_d = in_rd_wen;
        end else if (out_ready) begin
            // Payload is held; only the valid drops after consumption.
            out_valid_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        // Clearing a bit that is not set is harmless.
        if (w_wb_commit) begin
            pending_d[wb_waddr] = 1'b0;
        end
        // Applied after the clear: a new writer issued on the same edge
        // that the old write retires keeps the register pending.
        if (w_accept && in_rd_wen && (in_rd != c_R0)) begin
            pending_d[in_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q  <= 1'b0;
            out_op1_q    <= '0;
            out_op2_q    <= '0;
            out_rd_q     <= '0;
            out_rd_wen_q <= 1'b0;
            pending_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_op1_q    <= out_op1_d;
            out_op2_q    <= out_op2_d;
            out_rd_q     <= out_rd_d;
            out_rd_wen_q <= out_rd_wen_d;
            pending_q    <= pending_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_op1    = out_op1_q;
    assign out_op2    = out_op2_q;
    assign out_rd     = out_rd_q;
    assign out_rd_wen = out_rd_wen_q;
    assign pending    = pending_q;

endmodule
`default_nettype wire
